binary_div_22_11_uni: RTL

BINARY_DIV_22_11_UNI -- requirements
Module: binary_div_22_11_uni

---
 rtl/binary_div_22_11_uni.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/binary_div_22_11_uni.sv
// binary_div_22_11_uni: 22-bit by 11-bit unsigned radix-2 restoring divider.
// One quotient bit per enabled clock, MSB first; 22 enabled cycles from the
// accept edge to the done pulse. A zero divisor takes a one-cycle shortcut
// that returns an all-ones quotient, zero remainder and raises dz.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     clock enable; low freezes every register, outputs included
//   start  division request, accepted only in IDLE with en=1
//   N      22-bit unsigned dividend, captured on accept
//   D      11-bit unsigned divisor, captured on accept
//   Q      22-bit quotient (registered)
//   R      11-bit remainder (registered)
//   busy   division in progress
//   done   one-enabled-cycle result-valid pulse
//   dz     most recent result was a divide-by-zero
module binary_div_22_11_uni (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        start,
    input  logic [21:0] N,
    input  logic [10:0] D,
    output logic [21:0] Q,
    output logic [10:0] R,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    localparam int unsigned NW = 22;
    localparam int unsigned DW = 11;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_ITER = CW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DZERO = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [DW-1:0]  rem, rem_nx;
    logic [NW-1:0]  work, work_nx;      // dividend bits shift out, quotient bits shift in
    logic [DW-1:0]  dvs, dvs_nx;
    logic [NW-1:0]  q_nx;
    logic [DW-1:0]  r_nx;
    logic           busy_nx, done_nx, dz_nx;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    logic [DW:0]    partial;
    logic [DW:0]    diff;
    logic           fits;
    logic [DW-1:0]  rem_step;
    logic [NW-1:0]  work_step;

    assign partial   = {rem, work[NW-1]};
    assign diff      = partial - {1'b0, dvs};
    assign fits      = (partial >= {1'b0, dvs});
    // partial < divisor when it does not fit, so its MSB is zero and drops safely
    assign rem_step  = fits ? diff[DW-1:0] : partial[DW-1:0];
    assign work_step = {work[NW-2:0], fits};

    // State and datapath registers; en gates every update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            work  <= '0;
            dvs   <= '0;
            Q     <= '0;
            R     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else if (en) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rem   <= rem_nx;
            work  <= work_nx;
            dvs   <= dvs_nx;
            Q     <= q_nx;
            R     <= r_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            dz    <= dz_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rem_nx   = rem;
        work_nx  = work;
        dvs_nx   = dvs;
        q_nx     = Q;
        r_nx     = R;
        busy_nx  = busy;
        done_nx  = 1'b0;
        dz_nx    = dz;

        unique case (state)
            IDLE: begin
                if (start) begin
                    work_nx = N;
                    dvs_nx  = D;
                    rem_nx  = '0;
                    cnt_nx  = '0;
                    busy_nx = 1'b1;
                    if (D == '0) begin
                        state_nx = DZERO;
                    end else begin
                        state_nx = CALC;
                        dz_nx    = 1'b0;
                    end
                end
            end

            CALC: begin
                rem_nx  = rem_step;
                work_nx = work_step;
                cnt_nx  = cnt + CW'(1);
                if (cnt == LAST_ITER) begin
                    q_nx     = work_step;
                    r_nx     = rem_step;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end

            DZERO: begin
                q_nx     = '1;
                r_nx     = '0;
                dz_nx    = 1'b1;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
